// File: rtl/lcd_num_writer_if.sv
// CPU/LCD-side signal bundle for lcd_num_writer; slave = the sequencer, master = its driver.
interface lcd_num_writer_if;
  logic [15:0] numero;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;

  modport master (
    output numero, start,
    input  busy, done, lcd_data, lcd_rs, lcd_rw, lcd_en
  );

  modport slave (
    input  numero, start,
    output busy, done, lcd_data, lcd_rs, lcd_rw, lcd_en
  );
endinterface

// File: rtl/lcd_num_writer.sv
// Prints a signed 16-bit value on an HD44780 LCD as sign + 5 digits via serial double-dabble.
// Optional build macro LCD_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module lcd_num_writer #(
  parameter int unsigned EN_PULSE_CYC = 2,
  parameter int unsigned SETTLE_CYC   = 3,
  parameter logic [7:0]  CURSOR_CMD   = 8'h80
) (
  input logic             clk,
  input logic             rst_n,
  lcd_num_writer_if.slave lcd_io
);

  localparam int unsigned MaxPe  = (EN_PULSE_CYC > SETTLE_CYC) ? EN_PULSE_CYC : SETTLE_CYC;
  localparam int unsigned CntMax = (MaxPe > 16) ? MaxPe : 16;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] ConvLast = CntW'(15);
  localparam logic [CntW-1:0] EnLast   = CntW'(EN_PULSE_CYC - 1);
  localparam logic [CntW-1:0] SetLast  = CntW'(SETTLE_CYC - 1);

`ifdef LCD_ZERO_BLANK_EN
  localparam bit ZeroBlank = 1'b1;
`else
  localparam bit ZeroBlank = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StConv, StSetup, StEnHi, StEnLo} state_e;

  state_e          state_q;
  logic            sign_q;
  logic [15:0]     mag_q;
  logic [19:0]     bcd_q;
  logic [2:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      lcd_data_q;
  logic            lcd_rs_q;
  logic            lcd_en_q;
  logic [19:0]     bcd_adj;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Returns {rs, data} for transfer index i.
  function automatic logic [8:0] xfer_byte(input logic [2:0] i, input logic s,
                                           input logic [19:0] b);
    logic [3:0] dig;
    logic       lead_zero;
    logic [8:0] res;
    dig       = 4'd0;
    lead_zero = 1'b0;
    case (i)
      3'd2: begin dig = b[19:16]; lead_zero = (b[19:16] == 4'd0);  end
      3'd3: begin dig = b[15:12]; lead_zero = (b[19:12] == 8'd0);  end
      3'd4: begin dig = b[11:8];  lead_zero = (b[19:8]  == 12'd0); end
      3'd5: begin dig = b[7:4];   lead_zero = (b[19:4]  == 16'd0); end
      default: dig = b[3:0];
    endcase
    if (i == 3'd0) begin
      res = {1'b0, CURSOR_CMD};
    end else if (i == 3'd1) begin
      res = {1'b1, (s ? 8'h2D : 8'h20)};
    end else if (ZeroBlank && lead_zero) begin
      res = {1'b1, 8'h20};
    end else begin
      res = {1'b1, 4'h3, dig};
    end
    return res;
  endfunction

  assign bcd_adj = {dd_adj(bcd_q[19:16]), dd_adj(bcd_q[15:12]), dd_adj(bcd_q[11:8]),
                    dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lcd_io.start) begin
            sign_q  <= lcd_io.numero[15];
            mag_q   <= lcd_io.numero[15] ? (~lcd_io.numero + 16'd1) : lcd_io.numero;
            bcd_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          {bcd_q, mag_q} <= {bcd_adj[18:0], mag_q, 1'b0};
          if (cnt_q == ConvLast) begin
            // idx 0 is the cursor command, so it does not depend on the final BCD value
            {lcd_rs_q, lcd_data_q} <= xfer_byte(3'd0, sign_q, bcd_q);
            cnt_q   <= '0;
            state_q <= StSetup;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSetup: begin
          lcd_en_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= StEnHi;
        end
        StEnHi: begin
          if (cnt_q == EnLast) begin
            lcd_en_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StEnLo;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEnLo: begin
          if (cnt_q == SetLast) begin
            cnt_q <= '0;
            if (idx_q == 3'd6) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q                  <= idx_q + 3'd1;
              {lcd_rs_q, lcd_data_q} <= xfer_byte(idx_q + 3'd1, sign_q, bcd_q);
              state_q                <= StSetup;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lcd_io.busy     = busy_q;
  assign lcd_io.done     = done_q;
  assign lcd_io.lcd_data = lcd_data_q;
  assign lcd_io.lcd_rs   = lcd_rs_q;
  assign lcd_io.lcd_rw   = 1'b0;
  assign lcd_io.lcd_en   = lcd_en_q;

endmodule

// File: doc/lcd_num_writer.md
Name: lcd_num_writer

Overview:
- Sequencer that takes a 16-bit two's-complement value and prints it on an HD44780-style character LCD as 6 characters: a sign character followed by 5 decimal digits.
- Converts to BCD serially using 16-cycle double-dabble. This replaces a wide combinational divide/modulo chain.
- Issues one set-cursor command, then 6 data writes, each with a timed enable pulse.
- Sits between the CPU's display register and the LCD pins.

Parameters:
- EN_PULSE_CYC, 2, number of cycles lcd_en is held high per transfer (minimum 1).
- SETTLE_CYC, 3, number of cycles lcd_en is held low after each pulse before the next transfer (minimum 1).
- CURSOR_CMD, 8'h80, command byte sent with rs=0 to position the cursor before the characters.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- numero  in  16  signed value to display; sampled only when start is accepted.
- start  in  1  request to print; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance until the last settle completes.
- done  out  1  one-cycle pulse when the sequence completes.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_rw  out  1  constant 0 (write only).
- lcd_en  out  1  LCD enable strobe.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset is applied asynchronously, so lcd_en drops immediately even mid-pulse.
- States: IDLE, CONV, SETUP, EN_HI, EN_LO, then back to IDLE.
- IDLE:
  - done is low except for the single cycle after EN_LO of the last transfer.
  - On a clock edge with start=1, capture sign = numero[15].
  - Capture mag = sign ? (~numero + 1) : numero as 16-bit unsigned. -32768 gives 32768.
  - Clear the 20-bit BCD register, clear transfer index idx=0, go to CONV.
- CONV:
  - Runs exactly 16 cycles.
  - Each cycle: add 3 to every BCD nibble that is ≥5, then shift {bcd, mag} left by 1.
  - Then go to SETUP.
- Transfer sequence (idx 0..6):
  - idx 0 is CURSOR_CMD with rs=0.
  - idx 1 is the sign character: 0x2D if sign is 1, else 0x20.
  - idx 2..6 are 0x30 + digit, in order: ten-thousands, thousands, hundreds, tens, units. All with rs=1.
- SETUP: 1 cycle. Drive lcd_data and lcd_rs; lcd_en=0.
- EN_HI: EN_PULSE_CYC cycles with lcd_en=1. lcd_data and lcd_rs stay stable.
- EN_LO: SETTLE_CYC cycles with lcd_en=0. lcd_data and lcd_rs stay stable.
  - At the end of EN_LO, if idx<6, increment idx and go to SETUP.
  - Otherwise go to IDLE and assert done for that first IDLE cycle.
- Latency:
  - Let T = 1 + EN_PULSE_CYC + SETTLE_CYC.
  - done goes high in cycle 16 + 7·T + 1 counted after the accepting edge. This is 59 with the default parameters.
- busy is 1 in every non-IDLE state and 0 in the done cycle.
- Cycle counters use the minimum width for max(EN_PULSE_CYC, SETTLE_CYC, 16).
- start while busy is ignored, and numero changes while busy have no effect.
- start during the done cycle is accepted, because the FSM is already in IDLE; it behaves exactly like any IDLE start.
- Reset mid-sequence abandons the sequence. The next start after reset runs the full sequence from idx 0.
- lcd_en never toggles while lcd_data or lcd_rs is changing. Data changes only on entry to SETUP.

Optional Feature:
- Macro: LCD_ZERO_BLANK_EN.
- When defined: leading zero digits (idx 2..5) are sent as 0x20 until the first nonzero digit. The units digit (idx 6) is always printed. The sign stays at idx 1.
  - Example: -7 prints as "-    7".
- When not defined: all 5 digits are always printed with zeros.
  - Example: -7 prints as "-00007".
- Timing and latency are identical in both builds.

Test Plan:
- numero=16'd12345, start pulse. Required bytes on lcd_en rising edges: 0x80 (rs=0), then 0x20, 0x31, 0x32, 0x33, 0x34, 0x35 (rs=1). done goes high exactly 59 cycles after the accepting edge (defaults). busy is low in the done cycle.
- numero=16'hFFFF. Without the macro: 0x2D, 0x30, 0x30, 0x30, 0x30, 0x31. With LCD_ZERO_BLANK_EN: 0x2D, 0x20, 0x20, 0x20, 0x20, 0x31.
- numero=16'h8000 → 0x2D, 0x33, 0x32, 0x37, 0x36, 0x38. numero=16'h0000 → 0x20, 0x30 ×5 without the macro, or 0x20 ×5 then 0x30 with it.
- Start with 16'd42, then pulse start with 16'd999 at cycle 30. The second request is ignored and the output is 42. Then assert start with 16'd999 exactly in the done cycle: it is accepted, busy rises the next cycle, and the output is 999.
- Assert rst_n=0 asynchronously while lcd_en=1 during idx 3. lcd_en, busy and lcd_data go to 0 before the next clock edge. After release, start with 16'd7: a full 7-transfer sequence with correct bytes.
- Run with EN_PULSE_CYC=1, SETTLE_CYC=1. Each lcd_en high is exactly 1 cycle, each gap is at least 2 cycles, and done arrives at cycle 16 + 21 + 1 = 38.
